// File: rtl/cancid_stream_ctx.sv
// Per-stream regex engine context store: restores engine state at packet start, saves it at packet end.
// Optional per-stream hit counters with registered readback are enabled by CANCID_STREAM_CTX_PERSTREAM_CNT_EN.
module cancid_stream_ctx #(
   parameter int SW  = 11,
   parameter int NS  = 64,
   parameter int IDW = 6,
   parameter int CW  = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load_state,
   input  logic [IDW-1:0] stream_id,
   input  logic           enable,
   input  logic           eop,
   input  logic           accept_in,
   input  logic [SW-1:0]  eng_state_in,
   input  logic           flush_vld,
   input  logic [IDW-1:0] flush_id,
   output logic [SW-1:0]  eng_state_out,
   output logic           eng_state_vld,
   output logic           fired,
   output logic [CW-1:0]  count,
   output logic           active
`ifdef CANCID_STREAM_CTX_PERSTREAM_CNT_EN
   ,
   input  logic [IDW-1:0] rd_id,
   output logic [CW-1:0]  rd_count
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;

   state_t          state;
   state_t          state_nxt;
   logic [IDW-1:0]  cur_id;
   logic            cur_en;
   logic [NS-1:0]   valid;
   logic [SW-1:0]   state_mem [NS];
   logic [SW-1:0]   load_data;
   logic [SW-1:0]   load_rd;

   logic            in_active;
   logic            start;
   logic            save;
   logic            drop;
   logic            hit;
   logic            flush_cur;

   assign in_active = (state == ACTIVE);
   assign start     = load_state && (state != LOAD);
   assign save      = in_active && eop && cur_en;
   assign drop      = in_active && eop && !cur_en;
   assign hit       = fired || (in_active && accept_in);
   assign flush_cur = flush_vld && (flush_id == cur_id);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_state) state_nxt = LOAD;
         LOAD:    state_nxt = ACTIVE;
         ACTIVE: begin
            if (load_state)
               state_nxt = LOAD;
            else if (eop)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Restore value is captured at load_state; a save to the same id in that cycle bypasses the memory.
   always_comb begin
      load_rd = '0;
      if (flush_vld && (flush_id == stream_id))
         load_rd = '0;
      else if (save && (cur_id == stream_id))
         load_rd = eng_state_in;
      else if (valid[stream_id])
         load_rd = state_mem[stream_id];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cur_id    <= '0;
         cur_en    <= 1'b0;
         fired     <= 1'b0;
         count     <= '0;
         valid     <= '0;
         load_data <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            cur_id    <= stream_id;
            cur_en    <= enable;
            load_data <= load_rd;
         end
         if (start || drop)
            fired <= 1'b0;
         else if (in_active && accept_in)
            fired <= 1'b1;
         if (save && hit && (count != CNT_MAX))
            count <= count + CW'(1);
         if (save)
            valid[cur_id] <= 1'b1;
         if (flush_vld)
            valid[flush_id] <= 1'b0;
      end
   end

   // Context memory is deliberately not reset; the valid bits mark stale entries.
   always_ff @(posedge clk) begin
      if (save)
         state_mem[cur_id] <= eng_state_in;
   end

   assign eng_state_vld = (state == LOAD);
   assign eng_state_out = (state == LOAD && !flush_cur) ? load_data : '0;
   assign active        = in_active;

`ifdef CANCID_STREAM_CTX_PERSTREAM_CNT_EN
   logic [CW-1:0] hit_cnt [NS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NS; i++)
            hit_cnt[i] <= '0;
         rd_count <= '0;
      end else begin
         if (save && hit && (hit_cnt[cur_id] != CNT_MAX))
            hit_cnt[cur_id] <= hit_cnt[cur_id] + CW'(1);
         if (flush_vld)
            hit_cnt[flush_id] <= '0;
         rd_count <= hit_cnt[rd_id];
      end
   end
`endif

endmodule

// File: doc/cancid_stream_ctx.md
CANCID_STREAM_CTX -- requirements
Module: cancid_stream_ctx

Interface
REQ-001 SHALL have parameter SW, default 11, regex engine state width in bits.
REQ-002 SHALL have parameter NS, default 64, number of tracked streams; power of two, 2..1024.
REQ-003 SHALL have parameter IDW, default 6, stream id width, equal to log2(NS).
REQ-004 SHALL have parameter CW, default 16, packet-hit counter width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset, with these ports (clock and reset first):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_state  in  1  start of packet; samples stream_id and enable.
- stream_id  in  IDW  stream of the packet being started.
- enable  in  1  matcher enabled for this stream; sampled with load_state.
- eop  in  1  end of packet, single-cycle pulse.
- accept_in  in  1  match pulse from the regex engine.
- eng_state_in  in  SW  current regex engine state.
- flush_vld  in  1  invalidate one stream context.
- flush_id  in  IDW  stream to invalidate.
- eng_state_out  out  SW  restore state to the regex engine.
- eng_state_vld  out  1  one-cycle load strobe to the engine.
- fired  out  1  current packet has matched.
- count  out  CW  total matched, enabled packets.
- active  out  1  packet in progress (FSM in ACTIVE).

Function
REQ-006 SHALL use FSM states IDLE, LOAD and ACTIVE; IDLE goes to LOAD on load_state; LOAD goes to ACTIVE unconditionally after 1 cycle; ACTIVE goes to IDLE on eop, or to LOAD on load_state.
REQ-007 SHALL, on load_state, latch stream_id into cur_id and enable into cur_en, and clear fired.
REQ-008 SHALL, in LOAD, assert eng_state_vld for exactly 1 cycle: 1 cycle after load_state.
REQ-009 SHALL, in LOAD, drive eng_state_out with: state_mem[cur_id] if valid[cur_id]=1; otherwise 0.
REQ-010 SHALL set fired to 1 on accept_in while in ACTIVE; accept_in SHALL be ignored in IDLE and LOAD.
REQ-011 SHALL, on eop in ACTIVE with cur_en=1:
- write eng_state_in to state_mem[cur_id];
- set valid[cur_id];
- add fired to count, saturating at 2^CW-1.
REQ-012 SHALL, on eop in ACTIVE with cur_en=0, leave memory, valid bits and count unchanged, and clear fired.
REQ-013 SHALL ignore eop in IDLE and in LOAD.
REQ-014 SHALL, on eop and load_state in the same cycle in ACTIVE, commit the eop first (REQ-011/012), then enter LOAD.
REQ-015 SHALL, on load_state in ACTIVE without eop, abort the packet: no save, no count update.
REQ-016 SHALL bypass memory when a LOAD reads the same id written in the previous cycle: eng_state_out SHALL equal the just-saved value.
REQ-017 SHALL, on flush_vld, clear valid[flush_id]; if a save to the same id occurs in the same cycle, flush wins and valid ends at 0.
REQ-018 SHALL, on flush_vld with flush_id=cur_id during LOAD, drive eng_state_out=0.
REQ-019 SHALL hold fired until the next load_state (or until an eop with cur_en=0) so software can sample it after eop.

Reset
REQ-020 SHALL, on rst, set FSM=IDLE, fired=0, count=0, eng_state_vld=0, eng_state_out=0, active=0, all valid bits=0.
REQ-021 SHALL NOT reset state_mem contents; valid bits alone mark them stale.
REQ-022 SHALL, when rst is asserted mid-packet, discard the packet: no save, no count.

Configuration
REQ-023 SHALL support macro CANCID_STREAM_CTX_PERSTREAM_CNT_EN.
- Defined: add ports rd_id (in, IDW) and rd_count (out, CW), and an NS x CW per-stream hit counter array, incremented saturating alongside count and cleared by flush of that id.
- rd_count SHALL be registered, 1-cycle latency from rd_id; array SHALL be zeroed by rst.
- Undefined: no such ports or storage; all other behaviour identical.

Verification
REQ-024 SHALL cover a fresh stream: load_state id=5, enable=1; accept_in; eop with eng_state_in=0x2A5 -> eng_state_out=0 at LOAD, fired=1, count=1, valid[5]=1.
REQ-025 SHALL cover restore: reload id=5 -> eng_state_vld 1 cycle after load_state, with eng_state_out=0x2A5 and fired=0.
REQ-026 SHALL cover disabled and aborted packets: enable=0 packet with accept, then eop -> count unchanged, fired=0; load_state mid-ACTIVE -> no save of the old id.
REQ-027 SHALL cover eop+load_state same cycle: save id=3 state=0x111, new id=3 -> LOAD outputs 0x111 via bypass.
REQ-028 SHALL cover flush: flush id=5, then load id=5 -> eng_state_out=0; flush and save same cycle -> valid=0.
REQ-029 SHALL cover saturation and reset: CW=4, 17 matched packets -> count=15; assert rst mid-packet -> all outputs 0 and all streams reload as 0.
